// File: rtl/avalon_cmd_pkg.sv
// avalon_cmd_pkg: register map, STATUS bit positions and command FSM encodings for avalon_cmd_reg_bank
package avalon_cmd_pkg;
  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_RESULT = 2;
  localparam int REG_DATA0  = 3;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int CTRL_GO = 0;
  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;
endpackage

// File: rtl/avalon_byte_merge.sv
// avalon_byte_merge: per-lane write merge for DATA registers; lane-selective only when BYTEENABLE_EN is defined
module avalon_byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   cur,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);
`ifdef BYTEENABLE_EN
  for (genvar i = 0; i < DATA_W/8; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
  end
`else
  logic unused_lanes;
  assign unused_lanes = ^{cur, be};
  assign merged = wdata;
`endif
endmodule

// File: rtl/avalon_cmd_reg_bank.sv
// avalon_cmd_reg_bank: Avalon-MM CTRL/STATUS/RESULT command slave with exported DATA registers.
// BYTEENABLE_EN enables byte-lane writes and gates GO / W1C on byteenable[0].
module avalon_cmd_reg_bank
  import avalon_cmd_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              address,
  input  logic                           write,
  input  logic                           read,
  input  logic [DATA_W-1:0]              writedata,
  input  logic [DATA_W/8-1:0]            byteenable,
  output logic [DATA_W-1:0]              readdata,
  output logic                           readdatavalid,
  output logic                           hw_start,
  input  logic                           hw_done,
  input  logic [DATA_W-1:0]              hw_result,
  output logic [(NUM_REGS-3)*DATA_W-1:0] data_regs
);
  localparam int ND = NUM_REGS - REG_DATA0;
  logic state, done, err, lane0, busy, go_req, go_ok, go_err, hw_fin, wr_st;
  logic [DATA_W-1:0] result, rd_val;
  logic [DATA_W-1:0] data_q [ND];
  logic [DATA_W-1:0] merged [ND];
`ifdef BYTEENABLE_EN
  assign lane0 = byteenable[0];
`else
  assign lane0 = 1'b1;
`endif
  assign busy   = state == S_BUSY;
  assign go_req = write && int'(address) == REG_CTRL && lane0 && writedata[CTRL_GO];
  assign go_ok  = go_req && !busy;
  assign go_err = go_req && busy;
  assign hw_fin = hw_done && busy;
  assign wr_st  = write && int'(address) == REG_STATUS && lane0;
  for (genvar d = 0; d < ND; d++) begin : g_data
    avalon_byte_merge #(.DATA_W(DATA_W)) u_merge (
      .cur(data_q[d]), .wdata(writedata), .be(byteenable), .merged(merged[d])
    );
    assign data_regs[d*DATA_W +: DATA_W] = data_q[d];
  end
  always_comb begin
    rd_val = '0;
    if (int'(address) == REG_STATUS) begin
      rd_val[ST_BUSY] = busy;
      rd_val[ST_DONE] = done;
      rd_val[ST_ERR]  = err;
    end
    if (int'(address) == REG_RESULT) rd_val = result;
    for (int i = 0; i < ND; i++)
      if (int'(address) == REG_DATA0 + i) rd_val = data_q[i];
  end
  // set events take priority over W1C clears in the same cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= S_IDLE;
      done          <= 1'b0;
      err           <= 1'b0;
      result        <= '0;
      hw_start      <= 1'b0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
      for (int i = 0; i < ND; i++) data_q[i] <= '0;
    end else begin
      state         <= go_ok ? S_BUSY : hw_fin ? S_IDLE : state;
      done          <= hw_fin | (done & ~(wr_st & writedata[ST_DONE]));
      err           <= go_err | (err & ~(wr_st & writedata[ST_ERR]));
      hw_start      <= go_ok;
      readdatavalid <= read && !write;
      if (hw_fin) result <= hw_result;
      if (read && !write) readdata <= rd_val;
      for (int i = 0; i < ND; i++)
        if (write && int'(address) == REG_DATA0 + i) data_q[i] <= merged[i];
    end
endmodule

// File: tb/tb_avalon_cmd_reg_bank.sv
// tb_avalon_cmd_reg_bank: scoreboard bench; reads push expected data, a monitor pops on readdatavalid
module tb_avalon_cmd_reg_bank;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] address = '0;
  logic write = 1'b0, read = 1'b0, hw_done = 1'b0;
  logic [31:0] writedata = '0, hw_result = '0;
  logic [3:0] byteenable = 4'hF;
  logic [31:0] readdata;
  logic readdatavalid, hw_start;
  logic [159:0] data_regs;
  int errors = 0, checks = 0, starts = 0, s0 = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_be;

  avalon_cmd_reg_bank dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .readdatavalid(readdatavalid), .hw_start(hw_start), .hw_done(hw_done),
    .hw_result(hw_result), .data_regs(data_regs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: expects readdatavalid exactly one cycle after a read without write
  always @(posedge clk) begin
    logic v;
    v = read && !write && !reset;
    #1;
    if (hw_start) starts++;
    if (v || readdatavalid) chk("readdatavalid", {159'b0, readdatavalid}, {159'b0, v});
    if (readdatavalid) begin
      if (exp_q.size() == 0) chk("unexpected_read", 160'd1, 160'd0);
      else chk("readdata", {128'b0, readdata}, {128'b0, exp_q.pop_front()});
    end
  end

  task automatic cyc(input logic w, input logic r, input int a, input logic [31:0] d,
                     input logic [3:0] be, input logic hd, input logic [31:0] hr);
    @(negedge clk);
    write = w; read = r; address = 3'(a); writedata = d; byteenable = be;
    hw_done = hd; hw_result = hr;
  endtask
  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    cyc(1'b1, 1'b0, a, d, be, 1'b0, '0);
  endtask
  task automatic rd(input int a, input logic [31:0] e);
    exp_q.push_back(e);
    cyc(1'b0, 1'b1, a, '0, 4'hF, 1'b0, '0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, '0, 4'hF, 1'b0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_readdata", {128'b0, readdata}, 160'd0);
    chk("reset_hw_start", {159'b0, hw_start}, 160'd0);
    chk("reset_data_regs", data_regs, 160'd0);
    for (int a = 0; a < 8; a++) rd(a, 32'h0);
    idle(2);
    wr(3, 32'hDEADBEEF);
    wr(7, 32'h12345678);
    rd(3, 32'hDEADBEEF);
    rd(7, 32'h12345678);
    idle(2);
    chk("data_regs_lsb", {128'b0, data_regs[31:0]}, {128'b0, 32'hDEADBEEF});
    chk("data_regs_reg7", {128'b0, data_regs[159:128]}, {128'b0, 32'h12345678});
    wr(2, 32'hFFFFFFFF);
    rd(2, 32'h0);
    idle(2);
    s0 = starts;
    wr(0, 32'h1);
    rd(1, 32'h1);
    idle(3);
    chk("go_one_pulse", 160'(starts - s0), 160'd1);
    cyc(1'b0, 1'b0, 0, '0, 4'hF, 1'b1, 32'h00000ABC);
    rd(1, 32'h2);
    rd(2, 32'h00000ABC);
    wr(1, 32'h2);
    rd(1, 32'h0);
    idle(2);
    s0 = starts;
    wr(0, 32'h1);
    wr(0, 32'h1);
    wr(0, 32'h1);
    rd(1, 32'h5);
    idle(2);
    chk("busy_go_no_pulse", 160'(starts - s0), 160'd1);
    cyc(1'b1, 1'b0, 1, 32'h2, 4'hF, 1'b1, 32'h55);
    rd(1, 32'h6);
    rd(2, 32'h55);
    wr(1, 32'h6);
    rd(1, 32'h0);
    cyc(1'b1, 1'b1, 5, 32'h77, 4'hF, 1'b0, '0);
    rd(5, 32'h77);
    idle(2);
    wr(0, 32'h1);
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    s0 = starts;
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 0, '0, 4'hF, 1'b1, 32'h999);
    idle(2);
    rd(1, 32'h0);
    rd(2, 32'h0);
    rd(3, 32'h0);
    idle(2);
    chk("no_start_after_reset", 160'(starts - s0), 160'd0);
`ifdef BYTEENABLE_EN
    exp_be = 32'h11BB33DD;
`else
    exp_be = 32'hAABBCCDD;
`endif
    wr(4, 32'h11223344);
    wr(4, 32'hAABBCCDD, 4'b0101);
    rd(4, exp_be);
    idle(3);
    chk("scoreboard_drained", 160'(exp_q.size()), 160'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
